// File: rtl/alu_pkg.sv
// Shared opcode encodings for the 4-bit-operand ALU.
// Both the datapath and its users decode sel against these constants.
package alu_pkg;

  localparam int DW = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'b0000;
  localparam opcode_t OP_SUB  = 4'b0001;
  localparam opcode_t OP_MUL  = 4'b0010;
  localparam opcode_t OP_DIV  = 4'b0011;
  localparam opcode_t OP_MOD  = 4'b0100;
  localparam opcode_t OP_AND  = 4'b0101;
  localparam opcode_t OP_OR   = 4'b0110;
  localparam opcode_t OP_XOR  = 4'b0111;
  localparam opcode_t OP_NAND = 4'b1000;
  localparam opcode_t OP_NOR  = 4'b1001;
  localparam opcode_t OP_XNOR = 4'b1010;
  localparam opcode_t OP_SHL  = 4'b1011;
  localparam opcode_t OP_SHR  = 4'b1100;
  localparam opcode_t OP_NOT  = 4'b1101;
  localparam opcode_t OP_CMP  = 4'b1110;
  localparam opcode_t OP_INC  = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: 4-bit unsigned operands to a 16-bit result.
// All 16 opcodes are decoded, so every known sel selects a defined result.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]    a,
  input  logic [3:0]    b,
  input  opcode_t       sel,
  output logic [DW-1:0] res
);

  logic [DW-1:0] ax, bx;

  assign ax = {12'h000, a};
  assign bx = {12'h000, b};

  always_comb begin
    res = '0;
    case (sel)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      // Divide-by-zero saturates to all ones; modulo-by-zero passes a through.
      OP_DIV:  res = (b == 4'd0) ? 16'hFFFF : ax / bx;
      OP_MOD:  res = (b == 4'd0) ? ax : ax % bx;
      OP_AND:  res = {12'h000, a & b};
      OP_OR:   res = {12'h000, a | b};
      OP_XOR:  res = {12'h000, a ^ b};
      OP_NAND: res = {12'h000, ~(a & b)};
      OP_NOR:  res = {12'h000, ~(a | b)};
      OP_XNOR: res = {12'h000, ~(a ^ b)};
      OP_SHL:  res = ax << b;
      OP_SHR:  res = ax >> b;
      OP_NOT:  res = {12'h000, ~a};
      OP_CMP:  res = {13'h0000, a > b, a == b, a < b};
      OP_INC:  res = ax + 16'd1;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: result of alu_core captured every clk edge, 1-cycle latency.
// Synchronous active-high reset clears the output and overrides the datapath.
module alu
  import alu_pkg::*;
(
  output logic [DW-1:0] op,
  input  logic [3:0]    a,
  input  logic [3:0]    b,
  input  logic [3:0]    sel,
  input  logic          clk,
  input  logic          rst
);

  logic [DW-1:0] res;

  alu_core u_core (
    .a   (a),
    .b   (b),
    .sel (sel),
    .res (res)
  );

  always_ff @(posedge clk) begin
    if (rst) op <= '0;
    else     op <= res;
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expected results from a reference
// model, a monitor pops and compares one edge later.
module tb_alu;

  logic [15:0] op;
  logic [3:0]  a, b, sel;
  logic        clk, rst;

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];

  alu dut (
    .op  (op),
    .a   (a),
    .b   (b),
    .sel (sel),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input int x, input int y, input int s);
    int r;
    case (s)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x * y;
      3:  r = (y == 0) ? 65535 : x / y;
      4:  r = (y == 0) ? x : x % y;
      5:  r = x & y;
      6:  r = x | y;
      7:  r = x ^ y;
      8:  r = 15 - (x & y);
      9:  r = 15 - (x | y);
      10: r = 15 - (x ^ y);
      11: r = x * (1 << y);
      12: r = x / (1 << y);
      13: r = 15 - x;
      14: r = (x > y) ? 4 : (x == y) ? 2 : 1;
      default: r = x + 1;
    endcase
    return 16'(r & 32'hFFFF);
  endfunction

  task automatic drive(input logic r, input int ia, input int ib, input int is);
    @(negedge clk);
    rst = r;
    a   = 4'(ia);
    b   = 4'(ib);
    sel = 4'(is);
    sb.push_back(r ? 16'h0000 : model(ia, ib, is));
  endtask

  // Monitor: output is valid every edge; compare against the oldest expectation.
  always @(posedge clk) begin
    logic [15:0] exp;
    #1;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      n_vec++;
      if (op !== exp) begin
        n_fail++;
        $display("FAIL op: a=%0d b=%0d sel=%0d rst=%0b got %h expected %h",
                 a, b, sel, rst, op, exp);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; sel = '0;
    // Reset for two edges with arbitrary inputs, then release into ADD.
    drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    drive(1'b0, 13, 3, 0);
    // Full opcode sweep with a=13, b=3.
    for (int s = 0; s < 16; s++) drive(1'b0, 13, 3, s);
    // Boundary cases.
    drive(1'b0, 3, 13, 1);
    drive(1'b0, 3, 13, 14);
    drive(1'b0, 9, 0, 3);
    drive(1'b0, 9, 0, 4);
    drive(1'b0, 9, 0, 11);
    drive(1'b0, 15, 15, 11);
    drive(1'b0, 15, 15, 2);
    drive(1'b0, 15, 15, 15);
    drive(1'b0, 15, 15, 14);
    drive(1'b0, 9, 5, 12);
    // Sweep interrupted by reset, then resumed.
    for (int s = 0; s < 16; s++) begin
      if (s == 6) drive(1'b1, 13, 3, s);
      drive(1'b0, 13, 3, s);
    end
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(19) == 0), $urandom_range(15), $urandom_range(15),
            $urandom_range(15));
    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
